// File: rtl/cosmic_pkg.sv
// Shared definitions for the note path: note width, source indices, arbiter
// state encoding and the priority-pick helper.
package cosmic_pkg;
    localparam int NOTE_W     = 4;
    localparam int SRC_ADJUST = 0;
    localparam int SRC_FREE   = 1;
    localparam int SRC_AUTO   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Isolates the lowest set request bit; the lowest index has top priority.
    function automatic logic [2:0] lowest_req(input logic [2:0] r);
        return r & (~r + 3'd1);
    endfunction
endpackage

// File: rtl/hold_timer.sv
// Loadable up-counter that saturates at COUNT-1 and flags the terminal count.
module hold_timer #(
    parameter int COUNT = 4,
    parameter int W     = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic         done
);
    logic [W-1:0] count;

    assign done = (count == W'(COUNT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && !done) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/note_source_arbiter.sv
// Fixed-priority owner of the buzzer note path with a minimum note hold and a
// silence gap on every handover, so the tone generator never sees a glitch.
module note_source_arbiter #(
    parameter int NOTE_W     = cosmic_pkg::NOTE_W,
    parameter int MIN_HOLD   = 5_000_000,
    parameter int GAP_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [NOTE_W-1:0] note_in0,
    input  logic [NOTE_W-1:0] note_in1,
    input  logic [NOTE_W-1:0] note_in2,
    input  logic              mute,
    output logic [NOTE_W-1:0] note_out,
    output logic [2:0]        grant,
    output logic              note_start,
    output logic              busy
);
    import cosmic_pkg::*;

    arb_state_t        state;
    logic [2:0]        win;
    logic [NOTE_W-1:0] win_note;
    logic [NOTE_W-1:0] owner_note;
    logic              higher_req;
    logic              owner_drop;
    logic              leave;
    logic              hold_done;
    logic              gap_done;
    logic              hold_clear;
    logic              gap_clear;

    assign win = lowest_req(req);

    always_comb begin
        win_note = '0;
        if (win[SRC_ADJUST])    win_note = note_in0;
        else if (win[SRC_FREE]) win_note = note_in1;
        else if (win[SRC_AUTO]) win_note = note_in2;
    end

    always_comb begin
        owner_note = '0;
        if (grant[SRC_ADJUST])    owner_note = note_in0;
        else if (grant[SRC_FREE]) owner_note = note_in1;
        else if (grant[SRC_AUTO]) owner_note = note_in2;
    end

    // In PLAY note_out equals the latched note, so it doubles as the latch.
    assign higher_req = |(req & (grant - 3'd1));
    assign owner_drop = ~|(req & grant);
    assign leave      = higher_req | owner_drop | (owner_note != note_out);

    assign hold_clear = mute | (state != PLAY) | (hold_done & leave);
    assign gap_clear  = mute | (state != GAP) | gap_done;

    hold_timer #(.COUNT(MIN_HOLD)) u_hold (
        .clk      (clk),
        .reset    (reset),
        .clear    (hold_clear),
        .load     (1'b0),
        .load_val ('0),
        .enable   (state == PLAY),
        .done     (hold_done)
    );

    hold_timer #(.COUNT(GAP_CYCLES)) u_gap (
        .clk      (clk),
        .reset    (reset),
        .clear    (gap_clear),
        .load     (1'b0),
        .load_val ('0),
        .enable   (state == GAP),
        .done     (gap_done)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            note_out   <= '0;
            grant      <= '0;
            note_start <= 1'b0;
        end else if (mute) begin
            state      <= IDLE;
            note_out   <= '0;
            grant      <= '0;
            note_start <= 1'b0;
        end else begin
            note_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= PLAY;
                        grant      <= win;
                        note_out   <= win_note;
                        note_start <= 1'b1;
                    end
                end
                PLAY: begin
                    if (hold_done && leave) begin
                        state    <= GAP;
                        grant    <= '0;
                        note_out <= '0;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        if (|req) begin
                            state      <= PLAY;
                            grant      <= win;
                            note_out   <= win_note;
                            note_start <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    note_out <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_note_source_arbiter.sv
// Directed scenarios followed by random traffic, compared each cycle against a
// cycle-counting model of the owner / hold / gap rules.
module tb_note_source_arbiter;
    localparam int NOTE_W     = 4;
    localparam int MIN_HOLD   = 4;
    localparam int GAP_CYCLES = 2;

    logic              clk;
    logic              reset;
    logic [2:0]        req;
    logic [NOTE_W-1:0] note_in0;
    logic [NOTE_W-1:0] note_in1;
    logic [NOTE_W-1:0] note_in2;
    logic              mute;
    logic [NOTE_W-1:0] note_out;
    logic [2:0]        grant;
    logic              note_start;
    logic              busy;

    int vectors;
    int miscompares;

    // Reference model: who owns the path, what is sounding, how long the
    // current note or silence has been shown.
    int          m_owner;
    bit          m_gap;
    int          m_shown;
    logic [3:0]  m_note;
    bit          m_start;

    note_source_arbiter #(
        .NOTE_W     (NOTE_W),
        .MIN_HOLD   (MIN_HOLD),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .note_in0   (note_in0),
        .note_in1   (note_in1),
        .note_in2   (note_in2),
        .mute       (mute),
        .note_out   (note_out),
        .grant      (grant),
        .note_start (note_start),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_gap   = 1'b0;
        m_shown = 0;
        m_note  = '0;
        m_start = 1'b0;
    endtask

    task automatic model_arbitrate(input logic [2:0] r, input logic [3:0] n0,
                                   input logic [3:0] n1, input logic [3:0] n2);
        logic [3:0] nn [3];
        nn[0] = n0; nn[1] = n1; nn[2] = n2;
        m_gap   = 1'b0;
        m_note  = '0;
        m_start = 1'b0;
        m_owner = -1;
        for (int i = 0; i < 3; i++) begin
            if (r[i] && m_owner < 0) begin
                m_owner = i;
                m_note  = nn[i];
                m_shown = 1;
                m_start = 1'b1;
            end
        end
    endtask

    task automatic model_edge(input logic [2:0] r, input logic [3:0] n0,
                              input logic [3:0] n1, input logic [3:0] n2, input logic mt);
        logic [3:0] own_n;
        bit higher;
        if (mt) begin
            model_reset();
        end else if (m_owner >= 0) begin
            higher = 1'b0;
            for (int i = 0; i < 3; i++) if (i < m_owner && r[i]) higher = 1'b1;
            own_n = (m_owner == 0) ? n0 : (m_owner == 1) ? n1 : n2;
            m_start = 1'b0;
            if (m_shown >= MIN_HOLD && (higher || !r[m_owner] || own_n != m_note)) begin
                m_owner = -1;
                m_gap   = 1'b1;
                m_shown = 1;
                m_note  = '0;
            end else begin
                m_shown++;
            end
        end else if (m_gap && m_shown < GAP_CYCLES) begin
            m_shown++;
            m_start = 1'b0;
        end else begin
            model_arbitrate(r, n0, n1, n2);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [2:0] eg;
        eg = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        check({tag, ".note"},  note_out, m_note);
        check({tag, ".grant"}, {1'b0, grant}, {1'b0, eg});
        check({tag, ".start"}, {3'b0, note_start}, {3'b0, m_start});
        check({tag, ".busy"},  {3'b0, busy}, {3'b0, (m_owner >= 0) || m_gap});
    endtask

    task automatic step(input string tag);
        model_edge(req, note_in0, note_in1, note_in2, mute);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic drain();
        req  = 3'b000;
        mute = 1'b0;
        repeat (8) step("drain");
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, ".note"},  note_out, 4'h0);
        check({tag, ".grant"}, {1'b0, grant}, 4'h0);
        check({tag, ".start"}, {3'b0, note_start}, 4'h0);
        check({tag, ".busy"},  {3'b0, busy}, 4'h0);
        model_reset();
        #2 reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        req      = 3'b000;
        note_in0 = '0;
        note_in1 = '0;
        note_in2 = '0;
        mute     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        check("reset.note_const", note_out, 4'h0);
        reset = 1'b0;
        step("idle");

        // Single source, held then released.
        req = 3'b010; note_in1 = 4'd5;
        step("single");
        check("single.grant_const", {1'b0, grant}, 4'b0010);
        check("single.note_const", note_out, 4'd5);
        check("single.start_const", {3'b0, note_start}, 4'h1);
        repeat (6) step("single_hold");
        req = 3'b000;
        repeat (5) step("single_rel");
        check("single.idle_busy", {3'b0, busy}, 4'h0);

        // Preemption of the lowest-priority owner.
        req = 3'b100; note_in2 = 4'd7; note_in0 = 4'd9;
        step("preempt_grant");
        req = 3'b101;
        repeat (6) step("preempt");
        check("preempt.grant_const", {1'b0, grant}, 4'b0001);
        check("preempt.note_const", note_out, 4'd9);
        drain();

        // Simultaneous requests.
        req = 3'b111; note_in0 = 4'd1; note_in1 = 4'd2; note_in2 = 4'd3;
        step("simul");
        check("simul.grant_const", {1'b0, grant}, 4'b0001);
        repeat (12) step("simul_hold");
        drain();

        // Re-articulation by the current owner.
        req = 3'b010; note_in1 = 4'd3;
        repeat (4) step("reart_a");
        note_in1 = 4'd4;
        repeat (5) step("reart_b");
        drain();

        // Mute during the hold.
        req = 3'b001; note_in0 = 4'd2;
        repeat (2) step("mute_pre");
        mute = 1'b1;
        step("mute");
        check("mute.grant_const", {1'b0, grant}, 4'h0);
        check("mute.busy_const", {3'b0, busy}, 4'h0);
        mute = 1'b0; req = 3'b000;
        step("mute_post");

        // Asynchronous reset in the middle of a gap.
        req = 3'b010; note_in1 = 4'd6;
        step("rst_gap_grant");
        req = 3'b000;
        repeat (4) step("rst_gap_run");
        check("rst_gap.busy_const", {3'b0, busy}, 4'h1);
        async_reset_pulse("rst_gap");
        step("rst_gap_after");

        // One-cycle request still gets the full hold.
        req = 3'b010; note_in1 = 4'd8;
        step("short");
        req = 3'b000;
        repeat (7) step("short_run");
        drain();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) note_in0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) note_in1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) note_in2 = 4'($urandom_range(0, 15));
            mute = ($urandom_range(0, 49) == 0);
            step("rand");
            if (i == 300) async_reset_pulse("rand_rst");
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
